cameralink_medium_tx_framer: RTL

Transmit-side Camera Link Medium (2-chip, 4 x 12-bit pixels per clock) framer. It takes a 48-bit pixel stream with a valid/ready handshake and generates FVAL/LVAL/DVAL frame timing. It packs pixels and control into two 28-bit serializer words (X lanes, Y lanes) using the standard Medium port bit map. It sits in front of the 7:1 LVDS serializer and is used for loopback, camera emulation and receiver verification.

---
 rtl/cameralink_pkg.sv | 38 +++
 rtl/cameralink_medium_tx_framer_if.sv | 32 +++
 rtl/cameralink_tx_pack.sv | 58 +++++
 rtl/cameralink_medium_tx_framer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cameralink_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cameralink_pkg
//  Brief    : Shared constants and types for the Camera Link Medium TX framer.
//  Revision : 1.0 - initial release
// ============================================================================
package cameralink_pkg;

   localparam int PIX_W        = 12;
   localparam int PIX_PER_BEAT = 4;
   localparam int LANE_W       = 7;
   localparam int LANES        = 4;
   localparam int CHIP_W       = LANE_W * LANES;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FRONT  = 3'd1;
   localparam logic [2:0] ST_LINE   = 3'd2;
   localparam logic [2:0] ST_HBLANK = 3'd3;
   localparam logic [2:0] ST_VBLANK = 3'd4;

   // Control bits live in lane 2; the spare bit is lane 3 bit 0.
   localparam int LANE_DVAL_BIT  = 0;
   localparam int LANE_FVAL_BIT  = 1;
   localparam int LANE_LVAL_BIT  = 2;
   localparam int LANE_SPARE_BIT = 0;

   typedef struct packed {
      logic lval;
      logic fval;
      logic dval;
   } ctrl_t;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cameralink_medium_tx_framer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cameralink_medium_tx_framer_if
//  Brief    : Pixel-stream / serializer-word bundle for the Medium TX framer.
//  Revision : 1.0 - initial release
// ============================================================================
interface cameralink_medium_tx_framer_if;
   import cameralink_pkg::*;

   logic                           frame_start;
   logic [15:0]                    lineWidth;
   logic [15:0]                    frameHeight;
   logic [PIX_W*PIX_PER_BEAT-1:0]  pix_data;
   logic                           pix_vld;
   logic                           pix_rdy;
   logic [2*CHIP_W-1:0]            tx_data;
   logic                           busy;
   logic                           frame_done;
   logic [15:0]                    stall_cnt;

   modport master (
      output frame_start, lineWidth, frameHeight, pix_data, pix_vld,
      input  pix_rdy, tx_data, busy, frame_done, stall_cnt
   );

   modport slave (
      input  frame_start, lineWidth, frameHeight, pix_data, pix_vld,
      output pix_rdy, tx_data, busy, frame_done, stall_cnt
   );

endinterface
`default_nettype wire

// File: rtl/cameralink_tx_pack.sv
`default_nettype none
// ============================================================================
//  Module   : cameralink_tx_pack
//  Brief    : Maps one pixel pair plus LVAL/FVAL/DVAL onto 4 x 7 lane bits.
//  Revision : 1.0 - initial release
// ============================================================================
module cameralink_tx_pack
   import cameralink_pkg::*;
(
   input  logic [2*PIX_W-1:0] i_pair,
   input  ctrl_t              i_ctrl,
   output logic [CHIP_W-1:0]  o_lanes
);

   logic [7:0]        port_a;
   logic [7:0]        port_b;
   logic [7:0]        port_c;
   logic [LANE_W-1:0] lane0;
   logic [LANE_W-1:0] lane1;
   logic [LANE_W-1:0] lane2;
   logic [LANE_W-1:0] lane3;

   // Pair layout {px1, px0} lines up byte-wise with ports A/B/C.
   assign port_a = i_pair[7:0];
   assign port_b = i_pair[15:8];
   assign port_c = i_pair[23:16];

   always_comb begin
      lane0 = '0;
      lane1 = '0;
      lane2 = '0;
      lane3 = '0;

      lane0[0] = port_b[0];
      for (int i = 0; i < 6; i++) lane0[6-i] = port_a[i];

      for (int i = 0; i < 5; i++) lane1[6-i] = port_b[i+1];
      lane1[1] = port_c[0];
      lane1[0] = port_c[1];

      for (int i = 0; i < 4; i++) lane2[6-i] = port_c[i+2];
      lane2[LANE_LVAL_BIT] = i_ctrl.lval;
      lane2[LANE_FVAL_BIT] = i_ctrl.fval;
      lane2[LANE_DVAL_BIT] = i_ctrl.dval;

      lane3[6] = port_a[6];
      lane3[5] = port_a[7];
      lane3[4] = port_b[6];
      lane3[3] = port_b[7];
      lane3[2] = port_c[6];
      lane3[1] = port_c[7];
      lane3[LANE_SPARE_BIT] = 1'b0;
   end

   assign o_lanes = {lane3, lane2, lane1, lane0};

endmodule
`default_nettype wire

// File: rtl/cameralink_medium_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : cameralink_medium_tx_framer
//  Brief    : Camera Link Medium frame timing generator and X/Y lane packer.
//  Revision : 1.0 - initial release
// ============================================================================
module cameralink_medium_tx_framer
   import cameralink_pkg::*;
#(
   parameter int V_FRONT = 4,
   parameter int H_BLANK = 16,
   parameter int V_BLANK = 32
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   cameralink_medium_tx_framer_if.slave  bus
);

   localparam int BLANK_MAX = (V_FRONT > H_BLANK) ?
                              ((V_FRONT > V_BLANK) ? V_FRONT : V_BLANK) :
                              ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
   localparam int BLANK_W   = cnt_w(BLANK_MAX);

   localparam logic [BLANK_W-1:0] FRONT_LAST = BLANK_W'(V_FRONT - 1);
   localparam logic [BLANK_W-1:0] HBL_LAST   = BLANK_W'(H_BLANK - 1);
   localparam logic [BLANK_W-1:0] VBL_LAST   = BLANK_W'(V_BLANK - 1);

   logic [2:0]           state_q,  state_d;
   logic [BLANK_W-1:0]   blank_q,  blank_d;
   logic [13:0]          col_q,    col_d;
   logic [15:0]          line_q,   line_d;
   logic [13:0]          beats_q,  beats_d;
   logic [15:0]          height_q, height_d;
   logic [15:0]          stall_q,  stall_d;
   logic [2*CHIP_W-1:0]  tx_q,     tx_d;

   logic                 start_ok;
   logic                 last_beat;
   logic                 last_line;
   ctrl_t                ctrl;
   logic [PIX_W*PIX_PER_BEAT-1:0] pix_masked;
   logic [CHIP_W-1:0]    chip_lanes [2];

   assign start_ok  = bus.frame_start && (bus.lineWidth[15:2] != 14'd0)
                      && (bus.frameHeight != 16'd0);
   assign last_beat = (col_q == beats_q - 14'd1);
   assign last_line = (line_q == height_q - 16'd1);

   always_comb begin
      ctrl.lval = (state_q == ST_LINE);
      ctrl.fval = (state_q == ST_FRONT) || (state_q == ST_LINE) || (state_q == ST_HBLANK);
      ctrl.dval = ctrl.lval && bus.pix_vld;
   end

   always_comb begin
      state_d  = state_q;
      blank_d  = blank_q;
      col_d    = col_q;
      line_d   = line_q;
      beats_d  = beats_q;
      height_d = height_q;
      stall_d  = stall_q;

      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d  = ST_FRONT;
               beats_d  = bus.lineWidth[15:2];
               height_d = bus.frameHeight;
               stall_d  = '0;
               blank_d  = '0;
               col_d    = '0;
               line_d   = '0;
            end
         end
         ST_FRONT: begin
            if (blank_q == FRONT_LAST) begin
               state_d = ST_LINE;
               blank_d = '0;
            end else begin
               blank_d = blank_q + BLANK_W'(1);
            end
         end
         ST_LINE: begin
            if (!bus.pix_vld) begin
               if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
            end else if (last_beat) begin
               col_d   = '0;
               blank_d = '0;
               state_d = last_line ? ST_VBLANK : ST_HBLANK;
            end else begin
               col_d = col_q + 14'd1;
            end
         end
         ST_HBLANK: begin
            if (blank_q == HBL_LAST) begin
               state_d = ST_LINE;
               line_d  = line_q + 16'd1;
               blank_d = '0;
            end else begin
               blank_d = blank_q + BLANK_W'(1);
            end
         end
         ST_VBLANK: begin
            if (blank_q == VBL_LAST) begin
               state_d = ST_IDLE;
               blank_d = '0;
            end else begin
               blank_d = blank_q + BLANK_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stall cycles carry LVAL only; pixel bits are forced to zero.
   assign pix_masked = ctrl.dval ? bus.pix_data : '0;

   for (genvar g = 0; g < 2; g++) begin : g_chip
      cameralink_tx_pack u_pack (
         .i_pair  (pix_masked[g*2*PIX_W +: 2*PIX_W]),
         .i_ctrl  (ctrl),
         .o_lanes (chip_lanes[g])
      );
   end

   assign tx_d = {chip_lanes[1], chip_lanes[0]};

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q  <= ST_IDLE;
         blank_q  <= '0;
         col_q    <= '0;
         line_q   <= '0;
         beats_q  <= '0;
         height_q <= '0;
         stall_q  <= '0;
         tx_q     <= '0;
      end else begin
         state_q  <= state_d;
         blank_q  <= blank_d;
         col_q    <= col_d;
         line_q   <= line_d;
         beats_q  <= beats_d;
         height_q <= height_d;
         stall_q  <= stall_d;
         tx_q     <= tx_d;
      end
   end

   assign bus.tx_data    = tx_q;
   assign bus.pix_rdy    = (state_q == ST_LINE);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.frame_done = (state_q == ST_VBLANK) && (blank_q == VBL_LAST);
   assign bus.stall_cnt  = stall_q;

endmodule
`default_nettype wire
